// File: rtl/video_mem_responder_if.sv
// rtl/video_mem_responder_if.sv - video/CPU request and DRAM cycle bus for the memory responder
interface video_mem_responder_if #(
  parameter int ADDR_W = 21,
  parameter int DATA_W = 16
);
  logic              video_go;
  logic [1:0]        video_bw;
  logic [ADDR_W-1:0] video_addr;
  logic              video_next;
  logic              video_strobe;
  logic [DATA_W-1:0] video_data;

  logic              cpu_req;
  logic              cpu_rnw;
  logic [ADDR_W-1:0] cpu_addr;
  logic [DATA_W-1:0] cpu_wdata;
  logic              cpu_next;
  logic              cpu_strobe;
  logic [DATA_W-1:0] cpu_rdata;

  logic              dram_req;
  logic              dram_rnw;
  logic [ADDR_W-1:0] dram_addr;
  logic [DATA_W-1:0] dram_wdata;
  logic              dram_rrdy;
  logic [DATA_W-1:0] dram_rdata;

  // slave: the responder; master: requesters plus DRAM controller
  modport slave (
    input  video_go, video_bw, video_addr, cpu_req, cpu_rnw, cpu_addr, cpu_wdata,
           dram_rrdy, dram_rdata,
    output video_next, video_strobe, video_data, cpu_next, cpu_strobe, cpu_rdata,
           dram_req, dram_rnw, dram_addr, dram_wdata
  );

  modport master (
    output video_go, video_bw, video_addr, cpu_req, cpu_rnw, cpu_addr, cpu_wdata,
           dram_rrdy, dram_rdata,
    input  video_next, video_strobe, video_data, cpu_next, cpu_strobe, cpu_rdata,
           dram_req, dram_rnw, dram_addr, dram_wdata
  );
endinterface

// File: rtl/video_mem_responder.sv
// rtl/video_mem_responder.sv - DRAM slot arbiter between video fetch and CPU, one cycle per cend period
module video_mem_responder #(
  parameter int ADDR_W = 21,
  parameter int DATA_W = 16
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic                     cend,
  input  logic                     pre_cend,
  video_mem_responder_if.slave     bus
);
  typedef enum logic [1:0] {OWN_NONE, OWN_VIDEO, OWN_CPU} owner_t;

  owner_t            owner, next_owner, decide;
  logic [2:0]        slot;
  logic              done;
  logic              video_slot;
  logic              video_next, video_strobe, cpu_next, cpu_strobe;
  logic              dram_req, dram_rnw;
  logic [ADDR_W-1:0] dram_addr;
  logic [DATA_W-1:0] dram_wdata, video_data, cpu_rdata;

  always_comb begin
    video_slot = 1'b0;
    case (bus.video_bw)
      2'b00:   video_slot = (slot == 3'd0);
      2'b01:   video_slot = (slot[1:0] == 2'd0);
      default: video_slot = (slot[0] == 1'b0);
    endcase
    decide = OWN_NONE;
    if (bus.video_go && video_slot) decide = OWN_VIDEO;
    else if (bus.cpu_req)           decide = OWN_CPU;
  end

  // Decision is taken on pre_cend so the next pulses line up with the cend clk itself
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      owner <= OWN_NONE; next_owner <= OWN_NONE; slot <= 3'd0; done <= 1'b0;
      video_next <= 1'b0; video_strobe <= 1'b0; cpu_next <= 1'b0; cpu_strobe <= 1'b0;
      dram_req <= 1'b0; dram_rnw <= 1'b0; dram_addr <= '0; dram_wdata <= '0;
      video_data <= '0; cpu_rdata <= '0;
    end else begin
      video_next   <= 1'b0;
      cpu_next     <= 1'b0;
      video_strobe <= 1'b0;
      cpu_strobe   <= 1'b0;

      if (!bus.video_go) slot <= 3'd0;
      else if (cend)     slot <= slot + 3'd1;

      if (pre_cend) begin
        next_owner <= decide;
        video_next <= (decide == OWN_VIDEO);
        cpu_next   <= (decide == OWN_CPU);
      end

      if (cend) begin
        owner      <= next_owner;
        next_owner <= OWN_NONE;
        done       <= 1'b0;
        case (next_owner)
          OWN_VIDEO: begin
            dram_req <= 1'b1; dram_rnw <= 1'b1;
            dram_addr <= bus.video_addr; dram_wdata <= '0;
          end
          OWN_CPU: begin
            dram_req <= 1'b1; dram_rnw <= bus.cpu_rnw;
            dram_addr <= bus.cpu_addr; dram_wdata <= bus.cpu_wdata;
          end
          default: begin
            dram_req <= 1'b0; dram_rnw <= 1'b0;
            dram_addr <= '0; dram_wdata <= '0;
          end
        endcase
      end else if (bus.dram_rrdy && !done && owner != OWN_NONE) begin
        // Only the first ready of a period completes the cycle
        done <= 1'b1;
        if (owner == OWN_VIDEO) begin
          video_data   <= bus.dram_rdata;
          video_strobe <= 1'b1;
        end else begin
          if (dram_rnw) cpu_rdata <= bus.dram_rdata;
          cpu_strobe <= 1'b1;
        end
      end
    end
  end

  assign bus.video_next   = video_next;
  assign bus.video_strobe = video_strobe;
  assign bus.video_data   = video_data;
  assign bus.cpu_next     = cpu_next;
  assign bus.cpu_strobe   = cpu_strobe;
  assign bus.cpu_rdata    = cpu_rdata;
  assign bus.dram_req     = dram_req;
  assign bus.dram_rnw     = dram_rnw;
  assign bus.dram_addr    = dram_addr;
  assign bus.dram_wdata   = dram_wdata;
endmodule

// File: tb/tb_video_mem_responder.sv
// tb/tb_video_mem_responder.sv - directed vector bench for video_mem_responder
module tb_video_mem_responder;
  logic clk = 1'b0;
  logic rst_n = 1'b0;
  logic cend = 1'b0;
  logic pre_cend = 1'b0;
  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  video_mem_responder_if #(.ADDR_W(21), .DATA_W(16)) bus ();

  video_mem_responder #(.ADDR_W(21), .DATA_W(16)) dut (
    .clk(clk), .rst_n(rst_n), .cend(cend), .pre_cend(pre_cend), .bus(bus.slave)
  );

  typedef struct {
    logic        go;
    logic [1:0]  bw;
    logic [20:0] vaddr;
    logic        creq;
    logic        rnw;
    logic [20:0] caddr;
    logic [15:0] wdata;
    logic [15:0] rdata;
    logic        e_vnext;
    logic        e_cnext;
    logic        e_req;
    logic        e_rnw;
    logic [20:0] e_addr;
    logic [15:0] e_wdata;
    logic        e_vstb;
    logic        e_cstb;
    logic [15:0] e_vdata;
    logic [15:0] e_crdata;
  } vec_t;

  localparam int NV = 35;
  vec_t vecs[NV];

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic run_row(input int idx, input vec_t v);
    bus.video_go = v.go; bus.video_bw = v.bw; bus.video_addr = v.vaddr;
    bus.cpu_req = v.creq; bus.cpu_rnw = v.rnw; bus.cpu_addr = v.caddr;
    bus.cpu_wdata = v.wdata; bus.dram_rdata = v.rdata;
    pre_cend = 1'b1; tick(); pre_cend = 1'b0; cend = 1'b1;
    chk($sformatf("video_next[%0d]", idx), bus.video_next, v.e_vnext);
    chk($sformatf("cpu_next[%0d]", idx), bus.cpu_next, v.e_cnext);
    tick(); cend = 1'b0;
    chk($sformatf("next_pulse_end[%0d]", idx), {bus.video_next, bus.cpu_next}, 0);
    chk($sformatf("dram_req[%0d]", idx), bus.dram_req, v.e_req);
    if (v.e_req) begin
      chk($sformatf("dram_rnw[%0d]", idx), bus.dram_rnw, v.e_rnw);
      chk($sformatf("dram_addr[%0d]", idx), bus.dram_addr, v.e_addr);
    end
    if (v.e_cnext) chk($sformatf("dram_wdata[%0d]", idx), bus.dram_wdata, v.e_wdata);
    tick(); bus.dram_rrdy = 1'b1; tick(); bus.dram_rrdy = 1'b0;
    chk($sformatf("video_strobe[%0d]", idx), bus.video_strobe, v.e_vstb);
    chk($sformatf("cpu_strobe[%0d]", idx), bus.cpu_strobe, v.e_cstb);
    chk($sformatf("video_data[%0d]", idx), bus.video_data, v.e_vdata);
    chk($sformatf("cpu_rdata[%0d]", idx), bus.cpu_rdata, v.e_crdata);
    bus.dram_rdata = ~v.rdata; bus.dram_rrdy = 1'b1; tick(); bus.dram_rrdy = 1'b0;
    chk($sformatf("strobe_pulse_end[%0d]", idx), {bus.video_strobe, bus.cpu_strobe}, 0);
    tick();
    chk($sformatf("second_rrdy_strobe[%0d]", idx), {bus.video_strobe, bus.cpu_strobe}, 0);
    chk($sformatf("second_rrdy_vdata[%0d]", idx), bus.video_data, v.e_vdata);
    chk($sformatf("second_rrdy_crdata[%0d]", idx), bus.cpu_rdata, v.e_crdata);
    chk($sformatf("dram_req_held[%0d]", idx), bus.dram_req, v.e_req);
  endtask

  initial begin
    automatic logic [15:0] ev = 16'h0;
    automatic logic [15:0] ec = 16'h0;
    automatic int n = 0;
    automatic vec_t h;

    // bw=00, no CPU: video only on slot 0
    for (int i = 0; i < 16; i++) begin
      automatic logic vid = (i % 8 == 0);
      vecs[n] = '{1'b1, 2'b00, 21'h100 + 21'(i), 1'b0, 1'b1, 21'h0, 16'h0, 16'h1000 + 16'(i),
                  vid, 1'b0, vid, 1'b1, 21'h100 + 21'(i), 16'h0, vid, 1'b0, 16'h0, 16'h0};
      if (vid) ev = 16'h1000 + 16'(i);
      vecs[n].e_vdata = ev; vecs[n].e_crdata = ec; n++;
    end
    // bw=01 with CPU always requesting: video 0/4, CPU elsewhere
    for (int i = 0; i < 8; i++) begin
      automatic logic vid = (i % 4 == 0);
      vecs[n] = '{1'b1, 2'b01, 21'h300 + 21'(i), 1'b1, 1'b1, 21'h200 + 21'(i), 16'h0, 16'h2000 + 16'(i),
                  vid, !vid, 1'b1, 1'b1, vid ? 21'h300 + 21'(i) : 21'h200 + 21'(i), 16'h0,
                  vid, !vid, 16'h0, 16'h0};
      if (vid) ev = 16'h2000 + 16'(i); else ec = 16'h2000 + 16'(i);
      vecs[n].e_vdata = ev; vecs[n].e_crdata = ec; n++;
    end
    // bw=10: video on even slots at 0x1F000
    for (int i = 0; i < 8; i++) begin
      automatic logic vid = (i % 2 == 0);
      vecs[n] = '{1'b1, 2'b10, 21'h1F000, 1'b0, 1'b1, 21'h0, 16'h0, 16'hA55A,
                  vid, 1'b0, vid, 1'b1, 21'h1F000, 16'h0, vid, 1'b0, 16'h0, 16'h0};
      if (vid) ev = 16'hA55A;
      vecs[n].e_vdata = ev; vecs[n].e_crdata = ec; n++;
    end
    // CPU write with video idle: rdata must not change
    vecs[n] = '{1'b0, 2'b00, 21'h0, 1'b1, 1'b0, 21'h00123, 16'hBEEF, 16'h5A5A,
                1'b0, 1'b1, 1'b1, 1'b0, 21'h00123, 16'hBEEF, 1'b0, 1'b1, ev, ec}; n++;
    vecs[n] = '{1'b0, 2'b00, 21'h0, 1'b0, 1'b1, 21'h0, 16'h0, 16'h1111,
                1'b0, 1'b0, 1'b0, 1'b1, 21'h0, 16'h0, 1'b0, 1'b0, ev, ec}; n++;
    // video wins slot 0 over a pending CPU request
    ev = 16'h6666;
    vecs[n] = '{1'b1, 2'b00, 21'h55, 1'b1, 1'b1, 21'h44, 16'h0, 16'h6666,
                1'b1, 1'b0, 1'b1, 1'b1, 21'h55, 16'h0, 1'b1, 1'b0, ev, ec}; n++;

    bus.video_go = 0; bus.video_bw = 0; bus.video_addr = 0; bus.cpu_req = 0; bus.cpu_rnw = 1;
    bus.cpu_addr = 0; bus.cpu_wdata = 0; bus.dram_rrdy = 0; bus.dram_rdata = 0;
    tick(); tick();
    chk("reset_outputs", {bus.video_next, bus.video_strobe, bus.cpu_next, bus.cpu_strobe,
                          bus.dram_req, bus.dram_rnw}, 0);
    chk("reset_data", {bus.video_data, bus.cpu_rdata}, 0);
    chk("reset_dram_addr", bus.dram_addr, 0);
    rst_n = 1'b1; tick();

    for (int i = 0; i < n; i++) run_row(i, vecs[i]);

    // video_go dropped two clocks after a video cend: strobe still completes
    bus.video_go = 1'b0; tick();
    bus.video_go = 1'b1; bus.video_bw = 2'b00; bus.cpu_req = 1'b0;
    bus.video_addr = 21'h3333; bus.dram_rdata = 16'h7777;
    pre_cend = 1'b1; tick(); pre_cend = 1'b0; cend = 1'b1;
    chk("drop_vnext", bus.video_next, 1);
    tick(); cend = 1'b0;
    chk("drop_dram_addr", bus.dram_addr, 21'h3333);
    tick(); tick(); bus.video_go = 1'b0;
    bus.dram_rrdy = 1'b1; tick(); bus.dram_rrdy = 1'b0;
    chk("drop_strobe", bus.video_strobe, 1);
    chk("drop_vdata", bus.video_data, 16'h7777);
    tick();
    h = '{1'b0, 2'b00, 21'h3334, 1'b0, 1'b1, 21'h0, 16'h0, 16'h8888,
          1'b0, 1'b0, 1'b0, 1'b1, 21'h0, 16'h0, 1'b0, 1'b0, 16'h7777, ec};
    run_row(100, h);
    h = '{1'b1, 2'b00, 21'h3335, 1'b0, 1'b1, 21'h0, 16'h0, 16'h9999,
          1'b1, 1'b0, 1'b1, 1'b1, 21'h3335, 16'h0, 1'b1, 1'b0, 16'h9999, ec};
    run_row(101, h);

    // reset pulsed between cend and dram_rrdy
    bus.video_go = 1'b0; tick();
    bus.video_go = 1'b1; bus.video_addr = 21'h4444; bus.dram_rdata = 16'hCAFE;
    pre_cend = 1'b1; tick(); pre_cend = 1'b0; cend = 1'b1; tick(); cend = 1'b0;
    chk("rst_pre_req", bus.dram_req, 1);
    tick();
    rst_n = 1'b0; #1;
    chk("rst_async_outputs", {bus.video_next, bus.video_strobe, bus.cpu_next, bus.cpu_strobe,
                              bus.dram_req, bus.dram_rnw}, 0);
    chk("rst_async_data", {bus.video_data, bus.cpu_rdata}, 0);
    chk("rst_async_addr", bus.dram_addr, 0);
    bus.dram_rrdy = 1'b1; tick(); rst_n = 1'b1;
    tick(); bus.dram_rrdy = 1'b0;
    chk("rst_no_strobe", {bus.video_strobe, bus.cpu_strobe}, 0);
    tick();
    chk("rst_no_strobe_late", {bus.video_strobe, bus.cpu_strobe}, 0);
    chk("rst_vdata_zero", bus.video_data, 0);
    h = '{1'b1, 2'b00, 21'h4445, 1'b0, 1'b1, 21'h0, 16'h0, 16'hD00D,
          1'b1, 1'b0, 1'b1, 1'b1, 21'h4445, 16'h0, 1'b1, 1'b0, 16'hD00D, 16'h0};
    run_row(102, h);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
